bram_stream_reader: RTL and testbench

//  Port-B read sequencer for the dual-bank feature-map block RAM (bank 0 via enb, bank 1 via enb1).
//  On a start command it reads len consecutive words from one bank, beginning at base_addr.
//  It absorbs the 1-cycle BRAM read latency and emits the words as a valid/ready stream to the compute array.

---
 rtl/bram_stream_reader_pkg.sv | 8 +
 rtl/bram_stream_reader_if.sv | 32 +++
 rtl/bram_stream_reader_fifo.sv | 49 ++++
 rtl/bram_stream_reader.sv | 119 +++++++++++
 tb/tb_bram_stream_reader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bram_stream_reader_pkg.sv
// Shared defaults and types for the feature-map BRAM read path.
package cnn_mem_pkg;
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 8;
  localparam int BRAM_RD_LAT = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;
endpackage

// File: rtl/bram_stream_reader_if.sv
// Command, BRAM port-B and output stream bundle of the reader; slave = reader side.
interface bram_stream_reader_if
  import cnn_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic              bank_sel;
  logic              busy;
  logic              done;
  logic              enb;
  logic              enb1;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] doutb;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport slave (
    input  start, base_addr, len, bank_sel, doutb, m_ready,
    output busy, done, enb, enb1, addrb, m_data, m_valid, m_last
  );

  modport master (
    output start, base_addr, len, bank_sel, doutb, m_ready,
    input  busy, done, enb, enb1, addrb, m_data, m_valid, m_last
  );
endinterface

// File: rtl/bram_stream_reader_fifo.sv
// Two-entry register FIFO; 0-cycle read of the head, push and pop may coincide.
// Callers never push when full nor pop when empty.
module stream_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_dat_o,
  output logic [1:0]   count_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) count_d = count_q + 2'd1;
    if (!push_i && pop_i) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == 2'd2);
  assign empty_o   = (count_q == 2'd0);
endmodule

// File: rtl/bram_stream_reader.sv
// Port-B read sequencer: streams len words of one bank from base_addr; first beat 3 clks after start.
// Reads are throttled so buffered + in-flight words never exceed 2, so backpressure loses nothing.
module bram_stream_reader
  import cnn_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  bram_stream_reader_if.slave bus
);
  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;
  logic              bank_q, bank_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;

  logic              issue;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [1:0]        fifo_cnt;
  logic [DATA_W:0]   fifo_dat;

  assign pop = !fifo_empty && bus.m_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    addrb_d     = addrb_q;
    bank_d      = bank_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    done_d      = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = READ;
            addr_d  = bus.base_addr;
            rem_d   = bus.len;
            bank_d  = bus.bank_sel;
          end
        end
      end
      READ: begin
        // A same-cycle pop frees a slot, keeping 1 word/clk at full occupancy.
        if ((({1'b0, fifo_cnt} + {2'b00, infl_q}) < 3'd2) || pop) begin
          issue       = 1'b1;
          addrb_d     = addr_q;
          addr_d      = addr_q + ADDR_W'(1);
          rem_d       = rem_q - ADDR_W'(1);
          infl_d      = 1'b1;
          infl_last_d = (rem_q == ADDR_W'(1));
          if (rem_q == ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_dat[DATA_W]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      addrb_q     <= '0;
      bank_q      <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      addrb_q     <= addrb_d;
      bank_q      <= bank_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  // Each entry carries its last-of-job flag alongside the data word.
  stream_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (infl_q),
    .push_dat_i ({infl_last_q, bus.doutb}),
    .pop_i      (pop),
    .pop_dat_o  (fifo_dat),
    .count_o    (fifo_cnt),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign bus.enb     = issue && !bank_q;
  assign bus.enb1    = issue && bank_q;
  assign bus.addrb   = issue ? addr_q : addrb_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.m_valid = !fifo_empty;
  assign bus.m_data  = fifo_dat[DATA_W-1:0];
  assign bus.m_last  = !fifo_empty && fifo_dat[DATA_W];
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a two-bank BRAM model on port B.
module tb_bram_stream_reader;
  import cnn_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bram_stream_reader_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  bram_stream_reader #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] bank0 [65536];
  logic [7:0] bank1 [65536];

  always @(posedge clk) begin
    if (bus.enb)       bus.doutb <= bank0[bus.addrb];
    else if (bus.enb1) bus.doutb <= bank1[bus.addrb];
  end

  int checks   = 0;
  int failures = 0;

  int beats[$];
  int last_idx[$];
  int addrs[$];
  int first_vld, last_beat_cyc, done_cyc, done_cnt, busy_at_done, busy1;
  int enb_cnt, enb1_cnt, stab_err, iss10, vld_after, both_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int first, input int n);
    check({tag, "_count"}, beats.size(), n);
    for (int i = 0; i < n; i++) begin
      int obs;
      obs = (i < beats.size()) ? beats[i] : -1;
      check($sformatf("%s_beat%0d", tag, i), obs, first + i);
    end
  endtask

  // mode 0: ready always 1; 1: ready toggles starting high; 2: ready low for cycles 1..10.
  task automatic run_job(input logic [15:0] base, input logic [15:0] len, input logic bank,
                         input int mode, input int ign_c);
    int   c;
    logic prev_stall;
    logic [7:0] prev_dat;
    logic prev_last;
    beats.delete(); last_idx.delete(); addrs.delete();
    first_vld = 0; last_beat_cyc = 0; done_cyc = 0; done_cnt = 0; busy_at_done = -1;
    busy1 = -1; enb_cnt = 0; enb1_cnt = 0; stab_err = 0; iss10 = -1; vld_after = 0; both_en = 0;
    prev_stall = 1'b0; prev_dat = '0; prev_last = 1'b0;
    bus.start = 1'b1; bus.base_addr = base; bus.len = len; bus.bank_sel = bank;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 1;
    while (c <= 80) begin
      if (mode == 0)      bus.m_ready = 1'b1;
      else if (mode == 1) bus.m_ready = (c % 2 == 1);
      else                bus.m_ready = (c > 10);
      if (c == ign_c) begin
        bus.start = 1'b1; bus.base_addr = 16'h0050; bus.len = 16'd3; bus.bank_sel = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_dat || bus.m_last !== prev_last))
        stab_err++;
      if (c == 1) busy1 = bus.busy;
      if (bus.m_valid && first_vld == 0) first_vld = c;
      if (bus.enb) enb_cnt++;
      if (bus.enb1) enb1_cnt++;
      if (bus.enb && bus.enb1) both_en++;
      if (bus.enb || bus.enb1) addrs.push_back(bus.addrb);
      if (c == 10) iss10 = enb_cnt + enb1_cnt;
      if (bus.m_valid && bus.m_ready) begin
        beats.push_back(bus.m_data);
        if (bus.m_last) last_idx.push_back(beats.size());
        last_beat_cyc = c;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          busy_at_done = bus.busy;
        end
      end
      if (done_cyc != 0 && c > done_cyc && bus.m_valid) vld_after++;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_dat   = bus.m_data;
      prev_last  = bus.m_last;
      if (done_cyc != 0 && c >= done_cyc + 3) break;
      @(posedge clk); #1;
      c++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.bank_sel = 1'b0; bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) bank0[i] = 8'(i + 1);
    for (int i = 1; i < 5; i++) bank1[i] = 8'(i + 2);
    bank0[16'hFFFE] = 8'hA1;
    bank0[16'hFFFF] = 8'hA2;

    rst_n = 1'b0;
    #1;
    check("rst_busy",    bus.busy,    1'b0);
    check("rst_done",    bus.done,    1'b0);
    check("rst_en",      {bus.enb, bus.enb1}, 2'b00);
    check("rst_addrb",   bus.addrb,   16'h0000);
    check("rst_mvalid",  bus.m_valid, 1'b0);
    check("rst_mlast",   bus.m_last,  1'b0);
    check("rst_mdata",   bus.m_data,  8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-throughput job from bank 0
    run_job(16'h0000, 16'd5, 1'b0, 0, 0);
    check_seq("j1", 1, 5);
    check("j1_busy_c1",    busy1, 1);
    check("j1_first_vld",  first_vld, 3);
    check("j1_last_beat",  last_beat_cyc, 7);
    check("j1_last_cnt",   last_idx.size(), 1);
    check("j1_last_pos",   last_idx.size() > 0 ? last_idx[0] : 0, 5);
    check("j1_done_cyc",   done_cyc, 8);
    check("j1_done_cnt",   done_cnt, 1);
    check("j1_busy_done",  busy_at_done, 0);
    check("j1_enb_cnt",    enb_cnt, 5);
    check("j1_enb1_cnt",   enb1_cnt, 0);
    check("j1_vld_after",  vld_after, 0);

    // Bank 1 with toggling ready and a start pulse that must be ignored
    run_job(16'h0001, 16'd4, 1'b1, 1, 4);
    check_seq("j2", 3, 4);
    check("j2_enb_cnt",    enb_cnt, 0);
    check("j2_enb1_cnt",   enb1_cnt, 4);
    check("j2_stable",     stab_err, 0);
    check("j2_last_pos",   last_idx.size() > 0 ? last_idx[0] : 0, 4);
    check("j2_last_cnt",   last_idx.size(), 1);
    check("j2_done_cnt",   done_cnt, 1);
    check("j2_vld_after",  vld_after, 0);

    // Long backpressure at the start of the job
    run_job(16'h0000, 16'd5, 1'b0, 2, 0);
    check("j3_issued_c10", iss10, 2);
    check_seq("j3", 1, 5);
    check("j3_stable",     stab_err, 0);
    check("j3_last_pos",   last_idx.size() > 0 ? last_idx[0] : 0, 5);
    check("j3_done_cnt",   done_cnt, 1);
    check("j3_both_en",    both_en, 0);

    // Address wrap past 16'hFFFF
    run_job(16'hFFFE, 16'd4, 1'b0, 0, 0);
    check("j4_addr_cnt", addrs.size(), 4);
    check("j4_addr0", addrs.size() > 0 ? addrs[0] : -1, 32'h0000FFFE);
    check("j4_addr1", addrs.size() > 1 ? addrs[1] : -1, 32'h0000FFFF);
    check("j4_addr2", addrs.size() > 2 ? addrs[2] : -1, 32'h00000000);
    check("j4_addr3", addrs.size() > 3 ? addrs[3] : -1, 32'h00000001);
    check("j4_beat0", beats.size() > 0 ? beats[0] : -1, 32'hA1);
    check("j4_beat1", beats.size() > 1 ? beats[1] : -1, 32'hA2);
    check("j4_beat2", beats.size() > 2 ? beats[2] : -1, 32'h01);
    check("j4_beat3", beats.size() > 3 ? beats[3] : -1, 32'h02);
    check("j4_last_pos", last_idx.size() > 0 ? last_idx[0] : 0, 4);
    check("j4_last_cnt", last_idx.size(), 1);

    // Empty job
    run_job(16'h0003, 16'd0, 1'b1, 0, 0);
    check("j5_done_cyc",  done_cyc, 1);
    check("j5_done_cnt",  done_cnt, 1);
    check("j5_busy_c1",   busy1, 0);
    check("j5_enables",   enb_cnt + enb1_cnt, 0);
    check("j5_first_vld", first_vld, 0);

    // Reset while beat 2 is on the stream
    bus.m_ready = 1'b1;
    bus.start = 1'b1; bus.base_addr = 16'h0000; bus.len = 16'd5; bus.bank_sel = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("j6_pre_valid", bus.m_valid, 1'b1);
    check("j6_pre_data",  bus.m_data,  8'h02);
    rst_n = 1'b0;
    #1;
    check("j6_rst_busy",   bus.busy,    1'b0);
    check("j6_rst_en",     {bus.enb, bus.enb1}, 2'b00);
    check("j6_rst_addrb",  bus.addrb,   16'h0000);
    check("j6_rst_mvalid", bus.m_valid, 1'b0);
    check("j6_rst_mlast",  bus.m_last,  1'b0);
    check("j6_rst_mdata",  bus.m_data,  8'h00);
    check("j6_rst_done",   bus.done,    1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("j6_no_done", bus.done, 1'b0);
    run_job(16'h0002, 16'd3, 1'b0, 0, 0);
    check_seq("j6", 3, 3);
    check("j6_first_vld", first_vld, 3);
    check("j6_done_cyc",  done_cyc, 6);
    check("j6_done_cnt",  done_cnt, 1);
    check("j6_last_pos",  last_idx.size() > 0 ? last_idx[0] : 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
